// File: rtl/dm_access_unit.sv
// MEM-stage load/store unit driving a byte-lane data memory.
// Unaligned accesses that straddle a word boundary are issued as two aligned accesses.
module dm_access_unit #(
  parameter int DM_BYTES = 12288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_write_enable,
  output logic [31:0] dm_write_data,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_read_data
);

  typedef enum logic {IDLE, SPLIT} state_t;

  localparam logic [32:0] LAST_ADDR = 33'(DM_BYTES - 1);

  state_t      state, state_nx;

  logic [1:0]  off;
  logic [2:0]  n;
  logic [3:0]  size_mask;
  logic [32:0] addr_end;
  logic        req_err;
  logic        crosses;
  logic [7:0]  lane_span;
  logic [4:0]  sh_lo;
  logic        accept;

  logic [29:0] lat_word;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_write;
  logic        lat_signed;
  logic [3:0]  lat_we_hi;
  logic [31:0] lat_wdata;
  logic [31:0] lat_pc;
  logic [31:0] capture;
  logic [5:0]  sh_hi;

  logic [31:0] load_raw;
  logic [1:0]  load_size;
  logic        load_signed;
  logic [31:0] load_ext;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic sg);
    case (sz)
      2'd0:    extend = {{24{sg & v[7]}}, v[7:0]};
      2'd1:    extend = {{16{sg & v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  always_comb begin
    n         = 3'd4;
    size_mask = 4'b1111;
    case (req_size)
      2'd0: begin n = 3'd1; size_mask = 4'b0001; end
      2'd1: begin n = 3'd2; size_mask = 4'b0011; end
      default: ;
    endcase
  end

  assign off       = req_addr[1:0];
  // 33-bit sum so an access near 0xFFFFFFFF cannot wrap into the legal range
  assign addr_end  = {1'b0, req_addr} + {30'd0, n} - 33'd1;
  assign req_err   = (req_size == 2'd3) || (addr_end > LAST_ADDR);
  assign crosses   = ({1'b0, off} + n) > 3'd4;
  assign lane_span = {4'b0000, size_mask} << off;
  assign sh_lo     = {off, 3'b000};
  assign sh_hi     = 6'd32 - {1'b0, lat_off, 3'b000};
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nx        = state;
    req_ready       = 1'b0;
    dm_addr         = {req_addr[31:2], 2'b00};
    dm_write_enable = 4'b0000;
    dm_write_data   = req_wdata << sh_lo;
    dm_pc           = req_pc;
    load_raw        = dm_read_data >> sh_lo;
    load_size       = req_size;
    load_signed     = req_signed;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (accept && !req_err) begin
          if (req_write) dm_write_enable = lane_span[3:0];
          if (crosses) state_nx = SPLIT;
        end
      end
      SPLIT: begin
        dm_addr         = {lat_word + 30'd1, 2'b00};
        dm_write_enable = lat_write ? lat_we_hi : 4'b0000;
        dm_write_data   = lat_wdata >> sh_hi;
        dm_pc           = lat_pc;
        load_raw        = capture | (dm_read_data << sh_hi);
        load_size       = lat_size;
        load_signed     = lat_signed;
        state_nx        = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (reset) dm_write_enable = 4'b0000;
  end

  assign load_ext = extend(load_raw, load_size, load_signed);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      state      <= state_nx;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (state == SPLIT) begin
        resp_valid <= 1'b1;
        resp_rdata <= lat_write ? '0 : load_ext;
      end else if (accept) begin
        if (req_err) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end else if (!crosses) begin
          resp_valid <= 1'b1;
          resp_rdata <= req_write ? '0 : load_ext;
        end
      end
    end
  end

  // Context for the second half; capture keeps the low (4-off) bytes of a load
  always_ff @(posedge clk) begin
    if (accept && !req_err && crosses) begin
      lat_word   <= req_addr[31:2];
      lat_off    <= off;
      lat_size   <= req_size;
      lat_write  <= req_write;
      lat_signed <= req_signed;
      lat_we_hi  <= lane_span[7:4];
      lat_wdata  <= req_wdata;
      lat_pc     <= req_pc;
      capture    <= dm_read_data >> sh_lo;
    end
  end

endmodule

// File: doc/dm_access_unit.md
# dm_access_unit

Initiator-side load/store unit in the MEM stage that drives the data memory's byte-lane write-enable interface. It accepts byte, halfword and word load/store requests at any byte address. It generates little-endian lane enables and shifted write data, and returns extracted, sign- or zero-extended load data. Accesses that cross a word boundary are split into two consecutive aligned DM accesses, with the unit busy for the extra cycle.

## Interface
- DM_BYTES, 12288: DM capacity in bytes (3072 words); legal byte addresses are 0 .. DM_BYTES-1.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; has priority over every other input.
- req_valid  input  1  request present this cycle; accepted only when req_ready=1.
- req_ready  output  1  high iff state is IDLE and reset=0.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved (error).
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address; any alignment.
- req_wdata  input  32  store data, right-justified.
- req_pc  input  32  PC of the issuing instruction, forwarded to the DM.
- resp_valid  output  1  one-cycle pulse marking completion.
- resp_err  output  1  valid with resp_valid: range or size error.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
- dm_addr  output  32  word-aligned address to the DM (low 2 bits always 0).
- dm_write_enable  output  4  per-byte write enables; bit k writes dm_write_data[8k+7:8k].
- dm_write_data  output  32  lane-aligned store data.
- dm_pc  output  32  PC forwarded with the access.
- dm_read_data  input  32  combinational DM read of dm_addr.

## Operation
- Definitions: n = 1, 2 or 4 bytes for size 0, 1, 2; off = req_addr[1:0]; A = req_addr with low 2 bits cleared.
- Error condition: size==3, or req_addr + n - 1 > DM_BYTES-1 (compute with 33-bit arithmetic so the sum cannot wrap).
- FSM states:
  - IDLE: accepts requests.
  - SPLIT: second half of a crossing access.
- IDLE, request accepted with error:
  - dm_write_enable = 0.
  - Next cycle: resp_valid=1, resp_err=1, resp_rdata=0.
- IDLE, request accepted with off+n <= 4 (single word):
  - dm_addr = A.
  - Store: dm_write_enable = ((1<<n)-1) << off; dm_write_data = req_wdata << 8*off.
  - Load: capture (dm_read_data >> 8*off), masked to n bytes, then extended per req_signed.
  - Stay in IDLE; response registered for the next cycle.
- IDLE, request accepted with off+n > 4 (crossing):
  - First access: dm_addr = A; enables cover lanes off..3; write data shifted as above; load captures the low (4-off) bytes.
  - Latch the request; go to SPLIT.
- SPLIT:
  - dm_addr = A+4; dm_write_enable = (1<<(off+n-4))-1; dm_write_data = latched wdata >> 8*(4-off).
  - Load: merge (dm_read_data << 8*(4-off)) into the upper bytes of the capture, then extend.
  - Return to IDLE; response next cycle.
- A word at off=0 never splits. A halfword splits only at off=3.
- When not accessing (IDLE with no accepted request): dm_write_enable = 0; dm_addr, dm_write_data and dm_pc are don't-care but must stay deterministic.
- dm_pc = req_pc in IDLE, latched PC in SPLIT.
- Store responses: resp_err=0, resp_rdata=0.

## Timing
- Reset values: state = IDLE; resp_valid=0, resp_err=0, resp_rdata=0.
- While reset=1: dm_write_enable=0 and req_ready=0.
- Reset in SPLIT aborts the access: the second half is not written and no response is produced. The first half's write has already committed.
- Single-word access: accepted at cycle N, DM driven combinationally at N, resp_valid at N+1.
- Crossing access: DM accessed at N and N+1, req_ready=0 at N+1, resp_valid at N+2.
- Back-to-back single-word requests are accepted every cycle; each response follows one cycle later.
- req_valid while req_ready=0 is ignored; the requester must hold the request.
- resp_valid is high for exactly one cycle per accepted request.

## Test plan
- Store byte 0xA5 @0x0003, then load byte signed @0x0003 -> dm_write_enable=4'b1000, dm_write_data[31:24]=0xA5; load response 0xFFFFFFA5 at N+1.
- Store word 0x11223344 @0x0006 -> cycle N: addr 0x4, WE=4'b1100, data 0x33440000; cycle N+1: addr 0x8, WE=4'b0011, data 0x00001122. Then word load @0x6 -> 0x11223344 at N+2, req_ready=0 at N+1.
- Store half 0x8001 @0x000B, load half unsigned @0x000B -> split across 0x8/0xC; response 0x00008001.
- Word access @0x2FFE and byte access with size=3 -> resp_err=1, no DM write; word access @0x2FFC -> legal.
- Reset asserted during SPLIT of a word store @0x0001 -> address 0x0 written, address 0x4 not written, no resp_valid; req_ready=1 the cycle after reset releases.
- Four back-to-back aligned word loads -> accepted in consecutive cycles; four resp_valid pulses each one cycle later, in order.
